fetch_unit: RTL and testbench

Instruction fetch stage that owns the architectural PC and consumes pc_new-style redirects from the branch stage. It issues word-aligned requests to instruction memory over a valid/ready request channel with a valid-only response channel, and buffers fetched instructions with their PCs in a small FIFO. Decode reads the FIFO through a valid/ready handshake. A redirect flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's instruction-memory request and
// response channels, the branch-stage redirect and the decode-facing FIFO
// head.
//   imem_req_valid/ready/addr : word-aligned fetch request (valid/ready)
//   imem_rsp_valid/data       : valid-only instruction response
//   redirect_valid/pc         : branch/jump redirect from the branch stage
//   if_valid/ready/instr/pc   : fetched instruction + PC to decode
// master = fetch unit, slave = memory/branch/decode environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the architectural PC, issues one
// outstanding word-aligned request at a time, buffers {pc, instr} pairs in a
// DEPTH-entry FIFO for decode, and flushes on redirect (a response that was
// already in flight is drained and dropped).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_unit_if.master (imem request/response, redirect, decode)
//
// FSM states
//   state | meaning
//   IDLE  | no request outstanding
//   WAIT  | one request accepted, response pending and wanted
//   DRAIN | response pending but stale (redirect happened), discard it
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic can_issue;
  logic accept;
  logic push;
  logic pop;

  // Occupancy is the registered count; a pop in the same cycle is not
  // credited, which keeps the request path free of the decode ready.
  always_comb begin
    can_issue = 1'b0;
    if (state == IDLE)
      can_issue = (count < DEPTH_C);
    else if (state == WAIT)
      can_issue = bus.imem_rsp_valid && ((count + CW'(1)) < DEPTH_C);
  end

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && can_issue;
  assign bus.imem_req_addr  = pc & WORD_MASK;

  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign push   = (state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
  assign pop    = bus.if_valid && bus.if_ready;

  assign bus.if_valid = (count != '0);
  assign bus.if_instr = instr_mem[rd_ptr];
  assign bus.if_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC & WORD_MASK;
      req_pc <= '0;
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.redirect_valid) begin
      // Flush: a same-cycle pop has already handed the head to decode, so
      // simply re-aligning rd_ptr to wr_ptr empties the FIFO.
      pc     <= bus.redirect_pc & WORD_MASK;
      count  <= '0;
      rd_ptr <= wr_ptr;
      if (state == WAIT)
        state <= bus.imem_rsp_valid ? IDLE : DRAIN;
    end else begin
      if (accept) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      case (state)
        IDLE:    if (accept) state <= WAIT;
        WAIT:    if (bus.imem_rsp_valid) state <= accept ? WAIT : IDLE;
        DRAIN:   if (bus.imem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (RESET_PC=0x100,
// DEPTH=2). Stimulus pushes expected request addresses and expected decode
// {pc, instr} pairs; a monitor compares them as the DUT presents them. The
// memory model returns {16'hBEEF, addr[15:0]} after mem_lat cycles and only
// accepts as many requests as the current budget allows.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int budget = 0;
  int mem_lat = 1;

  logic [31:0] exp_req [$];
  logic [63:0] exp_dec [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_budget(input int n);
    budget = n;
    bus.imem_req_ready = (n > 0);
  endtask

  task automatic exp_pair(input logic [31:0] p, input logic [31:0] i);
    exp_dec.push_back({p, i});
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_req.size() != 0 && n < 50);
    if (exp_req.size() != 0) begin
      checks++;
      $display("FAIL %s: timeout, %0d requests still expected", name, exp_req.size());
      exp_req.delete();
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_dec.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_req.size() == 0 && exp_dec.size() == 0) passed++;
    else begin
      $display("FAIL %s: timeout, req left %0d dec left %0d required 0/0",
               name, exp_req.size(), exp_dec.size());
      exp_req.delete();
      exp_dec.delete();
    end
  endtask

  // Memory model
  logic        m_acc;
  logic [31:0] m_acc_addr;
  logic [31:0] m_pend_addr;
  int          m_pend_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      m_acc      = bus.imem_req_valid && bus.imem_req_ready;
      m_acc_addr = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (m_acc) begin
        budget--;
        m_pend_addr = m_acc_addr;
        m_pend_cnt  = mem_lat;
      end
      bus.imem_req_ready = (budget > 0);
      if (m_pend_cnt > 0) begin
        m_pend_cnt--;
        if (m_pend_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = {16'hBEEF, m_pend_addr[15:0]};
        end
      end
    end
  end

  // Monitor / scoreboard
  logic [31:0] mon_a;
  logic [63:0] mon_d;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_req_addr);
        end else begin
          mon_a = exp_req.pop_front();
          check32("req_addr", bus.imem_req_addr, mon_a);
        end
      end
      if (bus.if_valid && bus.if_ready) begin
        if (exp_dec.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pop: got pc %h instr %h expected no entry",
                   bus.if_pc, bus.if_instr);
        end else begin
          mon_d = exp_dec.pop_front();
          check32("if_pc", bus.if_pc, mon_d[63:32]);
          check32("if_instr", bus.if_instr, mon_d[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    // Reset
    tick();
    check32("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check32("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    rst = 1'b0;

    // 1: straight-line fetch from RESET_PC
    bus.if_ready = 1'b1;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h108);
    exp_pair(32'h100, 32'hBEEF_0100);
    exp_pair(32'h104, 32'hBEEF_0104);
    exp_pair(32'h108, 32'hBEEF_0108);
    set_budget(3);
    wait_drain("t1_drain");

    // 2: decode stalled, FIFO fills, fetch stops, then resumes
    bus.if_ready = 1'b0;
    exp_req.push_back(32'h10C);
    exp_req.push_back(32'h110);
    set_budget(2);
    wait_accept("t2_fill");
    repeat (3) tick();
    check32("t2_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check32("t2_head_pc", bus.if_pc, 32'h10C);
    check32("t2_head_instr", bus.if_instr, 32'hBEEF_010C);
    check32("t2_req_valid_full", {31'd0, bus.imem_req_valid}, 32'd0);
    set_budget(1);
    repeat (3) tick();
    check32("t2_req_valid_held", {31'd0, bus.imem_req_valid}, 32'd0);
    check32("t2_head_pc_held", bus.if_pc, 32'h10C);
    exp_req.push_back(32'h114);
    exp_pair(32'h10C, 32'hBEEF_010C);
    exp_pair(32'h110, 32'hBEEF_0110);
    exp_pair(32'h114, 32'hBEEF_0114);
    bus.if_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: redirect while WAIT, stale response two cycles later
    bus.if_ready = 1'b0;
    exp_req.push_back(32'h118);
    set_budget(1);
    wait_accept("t3_buf");
    tick();
    mem_lat = 2;
    exp_req.push_back(32'h11C);
    set_budget(1);
    wait_accept("t3_wait");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    check32("t3_if_valid_flushed", {31'd0, bus.if_valid}, 32'd0);
    check32("t3_req_valid_drain", {31'd0, bus.imem_req_valid}, 32'd0);
    mem_lat = 1;
    bus.if_ready = 1'b1;
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    exp_pair(32'h200, 32'hBEEF_0200);
    exp_pair(32'h204, 32'hBEEF_0204);
    set_budget(2);
    wait_drain("t3_drain");

    // 4: redirect to unaligned target with same-cycle response and pop
    bus.if_ready = 1'b0;
    exp_req.push_back(32'h208);
    set_budget(1);
    wait_accept("t4_buf");
    tick();
    exp_req.push_back(32'h20C);
    set_budget(1);
    wait_accept("t4_wait");
    exp_pair(32'h208, 32'hBEEF_0208);
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    @(negedge clk);
    check32("t4_req_valid_redirect", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    check32("t4_if_valid_empty", {31'd0, bus.if_valid}, 32'd0);
    exp_req.push_back(32'h200);
    exp_pair(32'h200, 32'hBEEF_0200);
    set_budget(1);
    wait_drain("t4_drain");

    // 5: redirect to top of address space, PC wraps
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_pair(32'hFFFF_FFFC, 32'hBEEF_FFFC);
    exp_pair(32'h0000_0000, 32'hBEEF_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    set_budget(2);
    tick();
    bus.redirect_valid = 1'b0;
    wait_drain("t5_drain");

    // 6: reset during WAIT, late response must be dropped
    mem_lat = 3;
    exp_req.push_back(32'h0000_0004);
    set_budget(1);
    wait_accept("t6_wait");
    rst = 1'b1;
    #1;
    check32("t6_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check32("t6_rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check32("t6_late_dropped", {31'd0, bus.if_valid}, 32'd0);
    mem_lat = 1;
    exp_req.push_back(32'h100);
    exp_pair(32'h100, 32'hBEEF_0100);
    set_budget(1);
    wait_drain("t6_drain");

    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
